sipo_frame_rx: RTL

// - Downstream consumer of the 4-bit serial-in/serial-out shift register: it takes
//   the serial bit stream that register shifts out and rebuilds WIDTH-bit parallel words.
// - Frame alignment comes from a sync marker.
// - Completed words are offered on a one-entry valid/ready output register.
// - Sticky flags record overflow and framing errors.

---
 rtl/sipo_frame_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx
// Serial-to-parallel frame receiver. It rebuilds WIDTH-bit words from a strobed
// serial stream that is aligned by a sync marker. Each finished word goes into a
// one-entry valid/ready output register. Sticky flags record dropped words and
// framing errors.
// Optional feature: define PARITY_CHECK_EN to expect one even-parity bit after
// every word. Without it, par_err is tied to 0.
// The datapath assumes WIDTH >= 2.

module sipo_frame_rx #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             ena,
    input  logic             sin,
    input  logic             sync,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err,
    output logic             par_err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    typedef enum logic {IDLE, SHIFT} state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shift_val;
    logic [WIDTH-1:0] restart_val;
    logic [WIDTH-1:0] done_word;
    logic             restart;
    logic             last_bit;
    logic             word_done;
    logic             load;
    logic             ovf_evt;
    logic             frm_evt;
`ifdef PARITY_CHECK_EN
    logic             par_ok;
    logic             par_fail;
`endif

    // Shift direction is chosen so that after WIDTH bits the first bit sits at dout[0] (LSB_FIRST) or dout[WIDTH-1]
    always_comb begin
        if (LSB_FIRST) begin
            shift_val   = {sin, sreg[WIDTH-1:1]};
            restart_val = {sin, {(WIDTH-1){1'b0}}};
        end else begin
            shift_val   = {sreg[WIDTH-2:0], sin};
            restart_val = {{(WIDTH-1){1'b0}}, sin};
        end
    end

    // Decode the receive events for this strobe: restart on sync, last data bit, word completion and errors
    always_comb begin
        restart   = ena & sync;
        frm_evt   = restart & (state != IDLE);
        last_bit  = (state == SHIFT) & ena & ~sync & (cnt == CW'(WIDTH - 1));
`ifdef PARITY_CHECK_EN
        par_ok    = ~^{sreg, sin};
        word_done = (state == PAR) & ena & ~sync & par_ok;
        par_fail  = (state == PAR) & ena & ~sync & ~par_ok;
        done_word = sreg;
`else
        word_done = last_bit;
        done_word = shift_val;
`endif
        load      = word_done & (~dout_valid | dout_ready);
        ovf_evt   = word_done & dout_valid & ~dout_ready;
    end

    // State register
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a sync strobe always restarts a word, and a plain strobe advances it
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (restart) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (restart) begin
                    state_nxt = SHIFT;
                end else if (last_bit) begin
`ifdef PARITY_CHECK_EN
                    state_nxt = PAR;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PAR: begin
                if (restart) begin
                    state_nxt = SHIFT;
                end else if (ena) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: busy while any part of a word is outstanding
    always_comb begin
        busy = (state != IDLE);
    end

    // Shift register and bit counter; a sync strobe discards any partial word and starts a new one
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (restart) begin
            sreg <= restart_val;
            cnt  <= CW'(1);
        end else if (ena && state == SHIFT) begin
            sreg <= shift_val;
            if (last_bit) begin
`ifdef PARITY_CHECK_EN
                cnt <= CW'(WIDTH);
`else
                cnt <= '0;
`endif
            end else begin
                cnt <= cnt + CW'(1);
            end
`ifdef PARITY_CHECK_EN
        end else if (ena && state == PAR) begin
            cnt <= '0;
`endif
        end
    end

    // One-entry output register: load when empty or draining this edge, otherwise clear valid on acceptance
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (load) begin
            dout       <= done_word;
            dout_valid <= 1'b1;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

    // Sticky error flags; an error event in the same cycle as clr wins
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= (overflow & ~clr) | ovf_evt;
            frame_err <= (frame_err & ~clr) | frm_evt;
        end
    end

`ifdef PARITY_CHECK_EN
    // Sticky parity error flag; a parity failure in the same cycle as clr wins
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            par_err <= 1'b0;
        end else begin
            par_err <= (par_err & ~clr) | par_fail;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule
